// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite register-bank responder with independent write (AW/W/B) and read (AR/R) paths.
// Optional build macro AXIL_SLV_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi4_lite_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]              AWPROT,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]              ARPROT,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [NUM_REGS-1:0]     wr_pulse
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int TAG_LSB  = ADDR_LSB + IDX_W;

  localparam logic [1:0] W_IDLE      = 2'd0;
  localparam logic [1:0] W_HAVE_ADDR = 2'd1;
  localparam logic [1:0] W_HAVE_DATA = 2'd2;
  localparam logic [1:0] W_RESP      = 2'd3;

  localparam logic R_IDLE = 1'b0;
  localparam logic R_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLV_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wr_pulse;

  // Write channel state
  logic [1:0]            r_wstate;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [IDX_W-1:0]      r_aw_idx;
  logic                  r_aw_oor;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;

  // Read channel state
  logic                  r_rstate;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic [IDX_W-1:0]      w_aw_idx;
  logic                  w_aw_oor;
  logic [IDX_W-1:0]      w_ar_idx;
  logic                  w_ar_oor;
  logic                  w_commit;
  logic [IDX_W-1:0]      w_c_idx;
  logic                  w_c_oor;
  logic [DATA_WIDTH-1:0] w_c_data;
  logic [STRB_W-1:0]     w_c_strb;
  logic                  w_c_we;
  logic [NUM_REGS-1:0]   w_reg_we;
  logic                  w_unused;

  assign w_aw_hs = AWVALID & r_awready;
  assign w_w_hs  = WVALID & r_wready;
  assign w_b_hs  = r_bvalid & BREADY;
  assign w_ar_hs = ARVALID & r_arready;
  assign w_r_hs  = r_rvalid & RREADY;

  // Any set bit above the register window makes the access out of range.
  assign w_aw_idx = AWADDR[ADDR_LSB +: IDX_W];
  assign w_aw_oor = |AWADDR[ADDR_WIDTH-1:TAG_LSB];
  assign w_ar_idx = ARADDR[ADDR_LSB +: IDX_W];
  assign w_ar_oor = |ARADDR[ADDR_WIDTH-1:TAG_LSB];

  assign w_unused = ^{AWPROT, ARPROT, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

  always_comb begin
    w_commit = 1'b0;
    case (r_wstate)
      W_IDLE:      w_commit = w_aw_hs & w_w_hs;
      W_HAVE_ADDR: w_commit = w_w_hs;
      W_HAVE_DATA: w_commit = w_aw_hs;
      default:     w_commit = 1'b0;
    endcase
  end

  // Whichever half arrived earlier comes from the capture registers, the other from the bus.
  assign w_c_idx  = (r_wstate == W_HAVE_ADDR) ? r_aw_idx : w_aw_idx;
  assign w_c_oor  = (r_wstate == W_HAVE_ADDR) ? r_aw_oor : w_aw_oor;
  assign w_c_data = (r_wstate == W_HAVE_DATA) ? r_wdata  : WDATA;
  assign w_c_strb = (r_wstate == W_HAVE_DATA) ? r_wstrb  : WSTRB;
  assign w_c_we   = w_commit & ~w_c_oor;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_we
      assign w_reg_we[gi] = w_c_we && (w_c_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_reg_we;
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int k = 0; k < STRB_W; k++) begin
          if (w_reg_we[i] && w_c_strb[k]) begin
            r_regs[i][8*k +: 8] <= w_c_data[8*k +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_aw_idx  <= '0;
      r_aw_oor  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_commit) begin
      r_wstate  <= W_RESP;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_c_oor ? RESP_OOR : RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_wstate  <= W_HAVE_ADDR;
            r_aw_idx  <= w_aw_idx;
            r_aw_oor  <= w_aw_oor;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
          end else if (w_w_hs) begin
            r_wstate  <= W_HAVE_DATA;
            r_wdata   <= WDATA;
            r_wstrb   <= WSTRB;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
          end else begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read samples the bank before this edge's write lands, so same-edge reads see old data.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rstate  <= R_DATA;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_ar_oor ? '0 : r_regs[w_ar_idx];
            r_rresp   <= w_ar_oor ? RESP_OOR : RESP_OKAY;
          end else begin
            r_arready <= 1'b1;
          end
        end
        default: begin
          if (w_r_hs) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign AWREADY  = r_awready;
  assign WREADY   = r_wready;
  assign BVALID   = r_bvalid;
  assign BRESP    = r_bresp;
  assign ARREADY  = r_arready;
  assign RVALID   = r_rvalid;
  assign RDATA    = r_rdata;
  assign RRESP    = r_rresp;
  assign wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs (32-bit data, 16 registers).
module tb_axi4_lite_slave_regs;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [15:0] wr_pulse;

`ifdef AXIL_SLV_SLVERR_EN
  localparam logic [1:0] EXP_OOR = 2'b10;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif

  int checks   = 0;
  int failures = 0;

  axi4_lite_slave_regs #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS  (16)
  ) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .AWADDR  (AWADDR),
    .AWPROT  (AWPROT),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARPROT  (ARPROT),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .wr_pulse(wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    ARADDR  = addr;
    ARVALID = 1'b1;
    RREADY  = 1'b1;
    n = 0;
    while (!ARREADY && n < 20) begin cyc(); n++; end
    cyc();
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 20) begin cyc(); n++; end
    chk("read_rvalid_seen", RVALID, 1'b1);
    data = RDATA;
    resp = RRESP;
    $display("read  addr=0x%08h data=0x%08h resp=%02b", addr, data, resp);
    cyc();
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    int n;
    AWADDR  = addr;
    WDATA   = data;
    WSTRB   = strb;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    BREADY  = 1'b1;
    n = 0;
    while (!(AWREADY && WREADY) && n < 20) begin cyc(); n++; end
    cyc();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    n = 0;
    while (!BVALID && n < 20) begin cyc(); n++; end
    chk("write_bvalid_seen", BVALID, 1'b1);
    $display("write addr=0x%08h data=0x%08h strb=%04b resp=%02b", addr, data, strb, BRESP);
    cyc();
  endtask

  // AW and W in the same cycle from an idle slave; checks the B response and the pulse timing.
  task automatic write_same_cycle(input string tag, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [3:0] strb,
                                  input logic [1:0] exp_resp, input logic [15:0] exp_pulse);
    AWADDR  = addr;
    WDATA   = data;
    WSTRB   = strb;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    BREADY  = 1'b1;
    chk({tag, "_ready"}, {AWREADY, WREADY}, 2'b11);
    cyc();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    chk({tag, "_bvalid"}, BVALID, 1'b1);
    chk({tag, "_bresp"}, BRESP, exp_resp);
    chk({tag, "_pulse"}, wr_pulse, exp_pulse);
    $display("write addr=0x%08h data=0x%08h strb=%04b resp=%02b pulse=%04h",
             addr, data, strb, BRESP, wr_pulse);
    cyc();
    chk({tag, "_bvalid_drop"}, BVALID, 1'b0);
    chk({tag, "_pulse_drop"}, wr_pulse, 16'h0000);
    chk({tag, "_awready_back"}, AWREADY, 1'b1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;

    ARESET  = 1'b1;
    AWADDR  = '0;
    AWPROT  = 3'b000;
    AWVALID = 1'b0;
    WDATA   = '0;
    WSTRB   = '0;
    WVALID  = 1'b0;
    BREADY  = 1'b1;
    ARADDR  = '0;
    ARPROT  = 3'b000;
    ARVALID = 1'b0;
    RREADY  = 1'b1;

    // Reset held three cycles
    repeat (3) cyc();
    chk("rst_awready_low", AWREADY, 1'b0);
    chk("rst_arready_low", ARREADY, 1'b0);
    ARESET = 1'b0;
    cyc();
    chk("rst_readys", {AWREADY, WREADY, ARREADY}, 3'b111);
    chk("rst_valids", {BVALID, RVALID}, 2'b00);
    chk("rst_resps", {BRESP, RRESP}, 4'b0000);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_pulse", wr_pulse, 16'h0000);
    axi_read(32'h04, rd, rr);
    chk("rst_read04", rd, 32'h0);
    chk("rst_read04_resp", rr, 2'b00);

    // Same-cycle write
    write_same_cycle("same_cyc", 32'h08, 32'hDEADBEEF, 4'hF, 2'b00, 16'h0004);
    axi_read(32'h08, rd, rr);
    chk("same_cyc_read", rd, 32'hDEADBEEF);

    // WSTRB=0 still pulses but changes nothing
    write_same_cycle("strb0", 32'h08, 32'h12345678, 4'h0, 2'b00, 16'h0004);
    axi_read(32'h08, rd, rr);
    chk("strb0_read", rd, 32'hDEADBEEF);

    // Split order, W first, AW three cycles later
    axi_write(32'h0C, 32'hFFFFFFFF, 4'hF);
    WDATA  = 32'h11223344;
    WSTRB  = 4'b0101;
    WVALID = 1'b1;
    BREADY = 1'b1;
    cyc();
    WVALID = 1'b0;
    chk("split_c1_wready", WREADY, 1'b0);
    chk("split_c1_awready", AWREADY, 1'b1);
    chk("split_c1_bvalid", BVALID, 1'b0);
    cyc();
    chk("split_c2_wready", WREADY, 1'b0);
    cyc();
    chk("split_c3_wready", WREADY, 1'b0);
    AWADDR  = 32'h0C;
    AWVALID = 1'b1;
    cyc();
    AWVALID = 1'b0;
    chk("split_c4_bvalid", BVALID, 1'b1);
    chk("split_c4_pulse", wr_pulse, 16'h0008);
    $display("split write addr=0x0000000c data=0x11223344 strb=0101 resp=%02b", BRESP);
    cyc();
    axi_read(32'h0C, rd, rr);
    chk("split_read", rd, 32'hFF22FF44);

    // B backpressure with a concurrent read
    AWADDR  = 32'h14;
    WDATA   = 32'h12345678;
    WSTRB   = 4'hF;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    BREADY  = 1'b0;
    cyc();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    chk("bp_bvalid_c1", BVALID, 1'b1);
    chk("bp_arready_c1", ARREADY, 1'b1);
    ARADDR  = 32'h00;
    ARVALID = 1'b1;
    RREADY  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 0) begin
        ARVALID = 1'b0;
        chk("bp_rvalid", RVALID, 1'b1);
        chk("bp_rdata", RDATA, 32'h0);
      end
      chk("bp_bvalid_hold", BVALID, 1'b1);
      chk("bp_bresp_hold", BRESP, 2'b00);
      chk("bp_readys_low", {AWREADY, WREADY}, 2'b00);
    end
    $display("backpressure write addr=0x00000014 held %0d cycles", 5);
    BREADY = 1'b1;
    cyc();
    chk("bp_bvalid_drop", BVALID, 1'b0);
    chk("bp_readys_back", {AWREADY, WREADY}, 2'b11);
    axi_read(32'h14, rd, rr);
    chk("bp_read", rd, 32'h12345678);

    // Read sampled on the commit edge of a write to the same register
    axi_write(32'h04, 32'hA5A5A5A5, 4'hF);
    AWADDR  = 32'h04;
    WDATA   = 32'h5A5A5A5A;
    WSTRB   = 4'hF;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    ARADDR  = 32'h04;
    ARVALID = 1'b1;
    cyc();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    ARVALID = 1'b0;
    chk("rdw_bvalid", BVALID, 1'b1);
    chk("rdw_rvalid", RVALID, 1'b1);
    chk("rdw_rdata_old", RDATA, 32'hA5A5A5A5);
    chk("rdw_pulse", wr_pulse, 16'h0002);
    $display("read-during-write addr=0x00000004 rdata=0x%08h", RDATA);
    cyc();
    axi_read(32'h04, rd, rr);
    chk("rdw_read_new", rd, 32'h5A5A5A5A);

    // Highest register and ignored low address bits
    write_same_cycle("reg15", 32'h3C, 32'h600DF00D, 4'hF, 2'b00, 16'h8000);
    axi_read(32'h3E, rd, rr);
    chk("reg15_read_lowbits", rd, 32'h600DF00D);

    // Out-of-range access
    write_same_cycle("oor_wr", 32'h40, 32'hCAFEF00D, 4'hF, EXP_OOR, 16'h0000);
    axi_read(32'h40, rd, rr);
    chk("oor_rdata", rd, 32'h0);
    chk("oor_rresp", rr, EXP_OOR);
    axi_read(32'h00, rd, rr);
    chk("oor_reg0_untouched", rd, 32'h0);
    chk("oor_reg0_resp", rr, 2'b00);
    axi_read(32'h0C, rd, rr);
    chk("oor_reg3_untouched", rd, 32'hFF22FF44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
